// File: rtl/fir_tap_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the FIR datapath control slice: pass-phase state
//   encoding, default tap count / multiplier latency, and the widths of the
//   tap-select and completed-pass counter buses used by the accumulator and
//   multiplier blocks.
// ----------------------------------------------------------------------------
package fir_pkg;

   localparam int unsigned TAP_NUM_DEF = 10;
   localparam int unsigned MUL_LAT_DEF = 1;
   localparam int unsigned SEL_W       = 4;
   localparam int unsigned CNT_W       = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_MUL   = 3'd2,
      ST_ACC   = 3'd3,
      ST_DONE  = 3'd4
   } firState_t;

   // Load value for a phase lasting n cycles on the down-counter (terminal at 0).
   function automatic logic [SEL_W-1:0] lastStep(input int unsigned n);
      return SEL_W'(n - 1);
   endfunction

endpackage

// File: rtl/fir_step_counter.sv
// ----------------------------------------------------------------------------
// fir_step_counter
//   Loadable down-counter with terminal-count flag, shared by the MUL and ACC
//   phases, plus a companion up-count register that tracks the step index
//   from zero while iTrackUp is held (used directly as the tap select).
//
//   iClk12M   in   clock, rising edge
//   iRsn      in   synchronous active-low reset
//   iLoad     in   load iLoadVal into the down-counter, restart up-count at 0
//   iLoadVal  in   WIDTH  down-counter load value
//   iDec      in   decrement down-counter / advance up-count
//   iTrackUp  in   keep up-count running; when low the up-count is held at 0
//   oUp       out  WIDTH  registered up-count (step index within phase)
//   oTc       out  down-counter has reached zero
// ----------------------------------------------------------------------------
module fir_step_counter
   import fir_pkg::*;
#(
   parameter int unsigned WIDTH = SEL_W
) (
   input  logic             iClk12M,
   input  logic             iRsn,
   input  logic             iLoad,
   input  logic [WIDTH-1:0] iLoadVal,
   input  logic             iDec,
   input  logic             iTrackUp,
   output logic [WIDTH-1:0] oUp,
   output logic             oTc
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge iClk12M) begin
      if (!iRsn) begin
         count <= '0;
         oUp   <= '0;
      end else begin
         if (iLoad) begin
            count <= iLoadVal;
         end else if (iDec) begin
            count <= count - WIDTH'(1);
         end

         if (!iTrackUp || iLoad) begin
            oUp <= '0;
         end else if (iDec) begin
            oUp <= oUp + WIDTH'(1);
         end
      end
   end

   assign oTc = (count == '0);

endmodule

// File: rtl/fir_tap_sequencer.sv
// ----------------------------------------------------------------------------
// fir_tap_sequencer
//   Control FSM for the FIR datapath. Each accepted input-sample strobe runs
//   one filter pass: shift delay line, multiply (MUL_LAT cycles), accumulate
//   TAP_NUM tap products in order, latch result. One early sample is buffered
//   in a pending flag; a further sample while pending is dropped and flagged.
//
//   Parameters: TAP_NUM (2..15) taps per pass, MUL_LAT (1..4) multiplier lat.
//
//   iClk12M    in   12 MHz clock, rising edge
//   iRsn       in   synchronous active-low reset
//   iEnSample  in   one-cycle new-sample strobe
//   iClrOvr    in   clear oOverrun (a same-cycle overrun wins)
//   oEnDelay   out  delay-line shift enable
//   oEnMul     out  multiplier-bank enable
//   oEnAdd     out  accumulator add enable
//   oSel       out  4   tap index during accumulate, 0 otherwise
//   oEnAcc     out  accumulator result-latch enable
//   oValid     out  filter output valid strobe
//   oBusy      out  pass in progress
//   oOverrun   out  sticky sample-dropped flag
//   oOutCnt    out  16  completed-pass counter (wraps)
// ----------------------------------------------------------------------------
module fir_tap_sequencer
   import fir_pkg::*;
#(
   parameter int unsigned TAP_NUM = TAP_NUM_DEF,
   parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
   input  logic             iClk12M,
   input  logic             iRsn,
   input  logic             iEnSample,
   input  logic             iClrOvr,
   output logic             oEnDelay,
   output logic             oEnMul,
   output logic             oEnAdd,
   output logic [SEL_W-1:0] oSel,
   output logic             oEnAcc,
   output logic             oValid,
   output logic             oBusy,
   output logic             oOverrun,
   output logic [CNT_W-1:0] oOutCnt
);

   firState_t        state;
   firState_t        stateNext;
   logic             pending;
   logic             pendingNext;
   logic             ovrSet;

   logic             stepLoad;
   logic [SEL_W-1:0] stepLoadVal;
   logic             stepDec;
   logic             stepTrack;
   logic             stepTc;

   // The up-count register doubles as the registered tap select: it tracks
   // only while the next state is ACC, so it reads 0 in every other state.
   fir_step_counter #(
      .WIDTH (SEL_W)
   ) uStep (
      .iClk12M  (iClk12M),
      .iRsn     (iRsn),
      .iLoad    (stepLoad),
      .iLoadVal (stepLoadVal),
      .iDec     (stepDec),
      .iTrackUp (stepTrack),
      .oUp      (oSel),
      .oTc      (stepTc)
   );

   // Next-state and pending/overrun decisions.
   always_comb begin
      stateNext   = state;
      pendingNext = pending;
      ovrSet      = 1'b0;

      case (state)
         ST_IDLE:  if (iEnSample) stateNext = ST_SHIFT;
         ST_SHIFT: stateNext = ST_MUL;
         ST_MUL:   if (stepTc) stateNext = ST_ACC;
         ST_ACC:   if (stepTc) stateNext = ST_DONE;
         ST_DONE: begin
            stateNext   = (pending || iEnSample) ? ST_SHIFT : ST_IDLE;
            // A buffered sample starts the next pass; a sample arriving in
            // the same cycle takes its place in the buffer.
            pendingNext = pending && iEnSample;
         end
         default:  stateNext = ST_IDLE;
      endcase

      if (iEnSample && (state == ST_SHIFT || state == ST_MUL || state == ST_ACC)) begin
         if (pending) begin
            ovrSet = 1'b1;
         end else begin
            pendingNext = 1'b1;
         end
      end
   end

   // Step-counter control: load on phase entry, count down while staying.
   always_comb begin
      stepLoad    = 1'b0;
      stepLoadVal = '0;
      stepDec     = 1'b0;
      stepTrack   = (stateNext == ST_ACC);

      if (stateNext == ST_MUL && state != ST_MUL) begin
         stepLoad    = 1'b1;
         stepLoadVal = lastStep(MUL_LAT);
      end else if (stateNext == ST_ACC && state != ST_ACC) begin
         stepLoad    = 1'b1;
         stepLoadVal = lastStep(TAP_NUM);
      end else if (stateNext == state && (state == ST_MUL || state == ST_ACC)) begin
         stepDec = 1'b1;
      end
   end

   // Outputs are registered from the next state so they align with it.
   always_ff @(posedge iClk12M) begin
      if (!iRsn) begin
         state    <= ST_IDLE;
         pending  <= 1'b0;
         oEnDelay <= 1'b0;
         oEnMul   <= 1'b0;
         oEnAdd   <= 1'b0;
         oEnAcc   <= 1'b0;
         oValid   <= 1'b0;
         oBusy    <= 1'b0;
         oOverrun <= 1'b0;
         oOutCnt  <= '0;
      end else begin
         state    <= stateNext;
         pending  <= pendingNext;
         oEnDelay <= (stateNext == ST_SHIFT);
         oEnMul   <= (stateNext == ST_MUL);
         oEnAdd   <= (stateNext == ST_ACC);
         oEnAcc   <= (stateNext == ST_DONE);
         oValid   <= (stateNext == ST_DONE);
         oBusy    <= (stateNext != ST_IDLE);

         if (ovrSet) begin
            oOverrun <= 1'b1;
         end else if (iClrOvr) begin
            oOverrun <= 1'b0;
         end

         if (stateNext == ST_DONE) begin
            oOutCnt <= oOutCnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;

   localparam int unsigned TA = 10;
   localparam int unsigned MA = 1;
   localparam int unsigned TB = 4;
   localparam int unsigned MB = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rsn, samp, clr;

   logic aDelay, aMul, aAdd, aAcc, aValid, aBusy, aOvr;
   logic [3:0] aSel;
   logic [15:0] aCnt;
   logic bDelay, bMul, bAdd, bAcc, bValid, bBusy, bOvr;
   logic [3:0] bSel;
   logic [15:0] bCnt;

   logic [26:0] vecA, vecB;
   assign vecA = {aDelay, aMul, aAdd, aSel, aAcc, aValid, aBusy, aOvr, aCnt};
   assign vecB = {bDelay, bMul, bAdd, bSel, bAcc, bValid, bBusy, bOvr, bCnt};

   fir_tap_sequencer #(.TAP_NUM(TA), .MUL_LAT(MA)) dutA (
      .iClk12M(clk), .iRsn(rsn), .iEnSample(samp), .iClrOvr(clr),
      .oEnDelay(aDelay), .oEnMul(aMul), .oEnAdd(aAdd), .oSel(aSel),
      .oEnAcc(aAcc), .oValid(aValid), .oBusy(aBusy), .oOverrun(aOvr),
      .oOutCnt(aCnt)
   );

   fir_tap_sequencer #(.TAP_NUM(TB), .MUL_LAT(MB)) dutB (
      .iClk12M(clk), .iRsn(rsn), .iEnSample(samp), .iClrOvr(clr),
      .oEnDelay(bDelay), .oEnMul(bMul), .oEnAdd(bAdd), .oSel(bSel),
      .oEnAcc(bAcc), .oValid(bValid), .oBusy(bBusy), .oOverrun(bOvr),
      .oOutCnt(bCnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference: a pass is a timeline of offsets 0..MUL+TAPS+1 from its start.
   typedef struct {
      bit          active;
      int unsigned off;
      bit          pend;
      bit          ovr;
      int unsigned cnt;
   } mdl_t;

   mdl_t mA, mB;

   function automatic mdl_t stepModel(mdl_t m, bit r, bit s, bit c,
                                      int unsigned mulLat, int unsigned taps);
      mdl_t n;
      int unsigned last;
      bit setOvr;
      n = m;
      last = mulLat + taps + 1;
      setOvr = 1'b0;
      if (!r) begin
         n.active = 0; n.off = 0; n.pend = 0; n.ovr = 0; n.cnt = 0;
         return n;
      end
      if (!m.active) begin
         if (s) begin n.active = 1; n.off = 0; end
      end else if (m.off == last) begin
         n.active = m.pend || s;
         n.off = 0;
         n.pend = m.pend && s;
      end else begin
         n.off = m.off + 1;
         if (s) begin
            if (m.pend) setOvr = 1'b1;
            else n.pend = 1'b1;
         end
         if (n.off == last) n.cnt = (m.cnt + 1) % 65536;
      end
      if (setOvr) n.ovr = 1'b1;
      else if (c) n.ovr = 1'b0;
      return n;
   endfunction

   function automatic logic [26:0] expOut(mdl_t m, int unsigned mulLat, int unsigned taps);
      logic [3:0] sel;
      bit dl, mu, ad, dn;
      sel = '0;
      dl = m.active && m.off == 0;
      mu = m.active && m.off >= 1 && m.off <= mulLat;
      ad = m.active && m.off > mulLat && m.off <= mulLat + taps;
      dn = m.active && m.off == mulLat + taps + 1;
      if (ad) sel = 4'(m.off - mulLat - 1);
      return {dl, mu, ad, sel, dn, dn, m.active, m.ovr, 16'(m.cnt)};
   endfunction

   task automatic tick(input bit r, input bit s, input bit c);
      rsn = r; samp = s; clr = c;
      @(posedge clk);
      mA = stepModel(mA, r, s, c, MA, TA);
      mB = stepModel(mB, r, s, c, MB, TB);
      #1;
   endtask

   task automatic test_reset();
      for (int unsigned i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
      checks++;
      if (vecA !== 27'd0) begin errors++; $display("FAIL reset_A got=%h exp=0", vecA); end
      checks++;
      if (vecB !== 27'd0) begin errors++; $display("FAIL reset_B got=%h exp=0", vecB); end
      for (int unsigned i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0, 1'b0);
         checks++;
         if (vecA !== 27'd0) begin errors++; $display("FAIL idle_A got=%h exp=0", vecA); end
      end
   endtask

   task automatic test_single();
      int vA = -1, vB = -1, mulA = 0, addA = 0, mulB = 0, addB = 0;
      for (int j = 0; j < 16; j++) begin
         tick(1'b1, j == 0, 1'b0);
         checks++;
         if (vecA !== expOut(mA, MA, TA)) begin
            errors++; $display("FAIL single_A off=%0d got=%h exp=%h", j + 1, vecA, expOut(mA, MA, TA));
         end
         checks++;
         if (vecB !== expOut(mB, MB, TB)) begin
            errors++; $display("FAIL single_B off=%0d got=%h exp=%h", j + 1, vecB, expOut(mB, MB, TB));
         end
         if (aValid === 1'b1 && vA < 0) vA = j + 1;
         if (bValid === 1'b1 && vB < 0) vB = j + 1;
         mulA += int'(aMul); addA += int'(aAdd);
         mulB += int'(bMul); addB += int'(bAdd);
      end
      checks++;
      if (vA != 13) begin errors++; $display("FAIL single_valid_A got=%0d exp=13", vA); end
      checks++;
      if (vB != 9) begin errors++; $display("FAIL single_valid_B got=%0d exp=9", vB); end
      checks++;
      if (mulA != 1 || addA != 10) begin errors++; $display("FAIL single_len_A mul=%0d add=%0d exp=1/10", mulA, addA); end
      checks++;
      if (mulB != 3 || addB != 4) begin errors++; $display("FAIL single_len_B mul=%0d add=%0d exp=3/4", mulB, addB); end
      checks++;
      if (aCnt !== 16'd1) begin errors++; $display("FAIL single_cnt_A got=%0d exp=1", aCnt); end
   endtask

   task automatic test_back_to_back();
      int vq[$];
      int busyA = 0, busyB = 0;
      for (int j = 0; j < 32; j++) begin
         tick(1'b1, j == 0 || j == 5, 1'b0);
         checks++;
         if (vecA !== expOut(mA, MA, TA)) begin
            errors++; $display("FAIL b2b_A off=%0d got=%h exp=%h", j + 1, vecA, expOut(mA, MA, TA));
         end
         checks++;
         if (vecB !== expOut(mB, MB, TB)) begin
            errors++; $display("FAIL b2b_B off=%0d got=%h exp=%h", j + 1, vecB, expOut(mB, MB, TB));
         end
         if (aValid === 1'b1) vq.push_back(j + 1);
         busyA += int'(aBusy);
         busyB += int'(bBusy);
      end
      checks++;
      if (vq.size() != 2 || vq[0] != 13 || vq[1] != 26) begin
         errors++; $display("FAIL b2b_valid_A n=%0d first=%0d exp 13,26", vq.size(), vq.size() > 0 ? vq[0] : -1);
      end
      checks++;
      if (busyA != 26 || busyB != 18) begin errors++; $display("FAIL b2b_busy got=%0d/%0d exp=26/18", busyA, busyB); end
      checks++;
      if (aOvr !== 1'b0) begin errors++; $display("FAIL b2b_ovr got=%b exp=0", aOvr); end
   endtask

   task automatic test_overrun();
      int nv = 0;
      for (int j = 0; j < 36; j++) begin
         tick(1'b1, j == 0 || j == 5 || j == 7, 1'b0);
         checks++;
         if (vecA !== expOut(mA, MA, TA)) begin
            errors++; $display("FAIL ovr_A off=%0d got=%h exp=%h", j + 1, vecA, expOut(mA, MA, TA));
         end
         checks++;
         if (vecB !== expOut(mB, MB, TB)) begin
            errors++; $display("FAIL ovr_B off=%0d got=%h exp=%h", j + 1, vecB, expOut(mB, MB, TB));
         end
         if (j == 6) begin
            checks++;
            if (aOvr !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b exp=0", aOvr); end
         end
         if (j == 7) begin
            checks++;
            if (aOvr !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", aOvr); end
         end
         nv += int'(aValid);
      end
      checks++;
      if (nv != 2) begin errors++; $display("FAIL ovr_nvalid got=%0d exp=2", nv); end
      tick(1'b1, 1'b0, 1'b1);
      checks++;
      if (aOvr !== 1'b0 || bOvr !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b%b exp=00", aOvr, bOvr); end
      // Overrun and clear in the same cycle: the overrun wins.
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      checks++;
      if (aOvr !== 1'b1) begin errors++; $display("FAIL ovr_prio got=%b exp=1", aOvr); end
      for (int j = 0; j < 30; j++) begin
         tick(1'b1, 1'b0, j == 29);
         checks++;
         if (vecA !== expOut(mA, MA, TA)) begin
            errors++; $display("FAIL ovr_tail_A got=%h exp=%h", vecA, expOut(mA, MA, TA));
         end
      end
   endtask

   task automatic test_continuous();
      int vq[$];
      int unsigned cnt0;
      cnt0 = aCnt;
      // A new sample lands in every DONE cycle: no gap, no buffering.
      for (int j = 0; j < 70; j++) begin
         tick(1'b1, j == 0 || (mA.active && mA.off == MA + TA + 1), 1'b0);
         checks++;
         if (vecA !== expOut(mA, MA, TA)) begin
            errors++; $display("FAIL cont_A off=%0d got=%h exp=%h", j + 1, vecA, expOut(mA, MA, TA));
         end
         checks++;
         if (vecB !== expOut(mB, MB, TB)) begin
            errors++; $display("FAIL cont_B off=%0d got=%h exp=%h", j + 1, vecB, expOut(mB, MB, TB));
         end
         if (aValid === 1'b1) vq.push_back(j + 1);
      end
      checks++;
      if (vq.size() != 5 || vq[0] != 13 || vq[4] != 65) begin
         errors++; $display("FAIL cont_valid n=%0d exp=5 (13..65)", vq.size());
      end
      checks++;
      if (int'(aCnt) != (cnt0 + 5) % 65536) begin errors++; $display("FAIL cont_cnt got=%0d exp=%0d", aCnt, (cnt0 + 5) % 65536); end
      checks++;
      if (aOvr !== 1'b0) begin errors++; $display("FAIL cont_ovr got=%b exp=0", aOvr); end
      for (int j = 0; j < 20; j++) tick(1'b1, 1'b0, 1'b0);
      // Strobe held high.
      vq.delete();
      for (int j = 0; j < 45; j++) begin
         tick(1'b1, 1'b1, 1'b0);
         checks++;
         if (vecA !== expOut(mA, MA, TA)) begin
            errors++; $display("FAIL held_A off=%0d got=%h exp=%h", j + 1, vecA, expOut(mA, MA, TA));
         end
         checks++;
         if (vecB !== expOut(mB, MB, TB)) begin
            errors++; $display("FAIL held_B off=%0d got=%h exp=%h", j + 1, vecB, expOut(mB, MB, TB));
         end
         if (aValid === 1'b1) vq.push_back(j + 1);
      end
      checks++;
      if (vq.size() != 3 || vq[0] != 13 || vq[1] != 26 || vq[2] != 39) begin
         errors++; $display("FAIL held_valid n=%0d exp=3 (13,26,39)", vq.size());
      end
      for (int j = 0; j < 30; j++) tick(1'b1, 1'b0, j == 29);
   endtask

   task automatic test_reset_mid();
      int nv = 0, vA = -1;
      for (int j = 0; j < 7; j++) tick(1'b1, j < 2, 1'b0);
      checks++;
      if (aSel !== 4'd4 || aAdd !== 1'b1) begin errors++; $display("FAIL mid_pre sel=%0d add=%b exp=4/1", aSel, aAdd); end
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (vecA !== 27'd0) begin errors++; $display("FAIL mid_rst_A got=%h exp=0", vecA); end
      checks++;
      if (vecB !== 27'd0) begin errors++; $display("FAIL mid_rst_B got=%h exp=0", vecB); end
      for (int j = 0; j < 20; j++) begin
         tick(1'b1, 1'b0, 1'b0);
         nv += int'(aValid) + int'(bValid) + int'(aBusy);
      end
      checks++;
      if (nv != 0) begin errors++; $display("FAIL mid_quiet got=%0d exp=0", nv); end
      for (int j = 0; j < 16; j++) begin
         tick(1'b1, j == 0, 1'b0);
         checks++;
         if (vecA !== expOut(mA, MA, TA)) begin
            errors++; $display("FAIL mid_fresh_A off=%0d got=%h exp=%h", j + 1, vecA, expOut(mA, MA, TA));
         end
         if (aValid === 1'b1 && vA < 0) vA = j + 1;
      end
      checks++;
      if (vA != 13 || aCnt !== 16'd1) begin errors++; $display("FAIL mid_fresh_pass valid=%0d cnt=%0d exp=13/1", vA, aCnt); end
   endtask

   task automatic test_random();
      bit r, s, c;
      for (int j = 0; j < 1500; j++) begin
         r = ($urandom_range(0, 149) != 0);
         s = ($urandom_range(0, 6) == 0);
         c = ($urandom_range(0, 15) == 0);
         tick(r, s, c);
         checks++;
         if (vecA !== expOut(mA, MA, TA)) begin
            errors++; $display("FAIL rand_A cyc=%0d got=%h exp=%h", j, vecA, expOut(mA, MA, TA));
         end
         checks++;
         if (vecB !== expOut(mB, MB, TB)) begin
            errors++; $display("FAIL rand_B cyc=%0d got=%h exp=%h", j, vecB, expOut(mB, MB, TB));
         end
      end
   endtask

   initial begin
      rsn = 1'b0; samp = 1'b0; clr = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_continuous();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
